// File: rtl/strum_press_gen_pkg.sv
// Shared event codes and channel state type for the strum/kick press generator.
package strum_pkg;

  localparam logic [1:0] EVT_UP   = 2'b01;
  localparam logic [1:0] EVT_DOWN = 2'b10;
  localparam logic [1:0] EVT_KICK = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HOLDOFF = 2'd2
  } chan_state_t;

endpackage

// File: rtl/strum_press_gen_if.sv
// Valid/ready event port toward the host logger.
interface strum_press_gen_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/strum_press_gen_press_channel.sv
// One input channel: rising-edge detect, press/holdoff timer FSM, pending-event request.
//   state   | meaning
//   IDLE    | armed, waiting for a rising edge
//   PRESS   | press output high for PRESS_CYCLES
//   HOLDOFF | dead time, rises ignored
module press_channel
  import strum_pkg::*;
#(
  parameter int PRESS_CYCLES   = 500000,
  parameter int HOLDOFF_CYCLES = 250000,
  parameter int CNT_W          = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic grant,
  output logic press,
  output logic pend,
  output logic start,
  output logic drop
);

  localparam int HOLD_LD_I = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_LD_I);

  chan_state_t      state;
  logic [CNT_W-1:0] timer;
  logic             prev;
  logic             rise;

  assign rise  = din & ~prev;
  assign start = (state == IDLE) & rise;
  assign press = (state == PRESS);
  // A grant on the same cycle frees the slot, so the new edge is kept rather than dropped.
  assign drop  = start & pend & ~grant;

  always_ff @(posedge clk) begin
    prev <= din;
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS;
            timer <= PRESS_LD;
          end
        end
        PRESS: begin
          if (timer == '0) begin
            if (HOLDOFF_CYCLES > 0) begin
              state <= HOLDOFF;
              timer <= HOLD_LD;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        HOLDOFF: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (start)      pend <= 1'b1;
      else if (grant) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/strum_press_gen.sv
// Press-pulse generator with fixed-priority event arbiter and FWFT event FIFO.
// Optional STRUM_PRESS_STATS_EN adds saturating per-channel press counters.
module strum_press_gen
  import strum_pkg::*;
#(
  parameter int PRESS_CYCLES   = 500000,
  parameter int HOLDOFF_CYCLES = 250000,
  parameter int CNT_W          = 20,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic strum_g,
  input  logic strum_b,
  input  logic drum_foot,
  output logic press_up,
  output logic press_down,
  output logic press_kick,
  strum_press_gen_if.master evt,
  output logic evt_overflow
`ifdef STRUM_PRESS_STATS_EN
  ,
  output logic [15:0] cnt_up,
  output logic [15:0] cnt_down,
  output logic [15:0] cnt_kick
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic pend_up, pend_down, pend_kick;
  logic g_up, g_down, g_kick;
  logic start_up, start_down, start_kick;
  logic drop_up, drop_down, drop_kick;

  press_channel #(.PRESS_CYCLES(PRESS_CYCLES), .HOLDOFF_CYCLES(HOLDOFF_CYCLES), .CNT_W(CNT_W))
    u_up (.clk(clk), .rst(rst), .din(strum_g), .grant(g_up), .press(press_up),
          .pend(pend_up), .start(start_up), .drop(drop_up));
  press_channel #(.PRESS_CYCLES(PRESS_CYCLES), .HOLDOFF_CYCLES(HOLDOFF_CYCLES), .CNT_W(CNT_W))
    u_down (.clk(clk), .rst(rst), .din(strum_b), .grant(g_down), .press(press_down),
            .pend(pend_down), .start(start_down), .drop(drop_down));
  press_channel #(.PRESS_CYCLES(PRESS_CYCLES), .HOLDOFF_CYCLES(HOLDOFF_CYCLES), .CNT_W(CNT_W))
    u_kick (.clk(clk), .rst(rst), .din(drum_foot), .grant(g_kick), .press(press_kick),
            .pend(pend_kick), .start(start_kick), .drop(drop_kick));

  logic [AW:0] wr_ptr, rd_ptr;
  logic [1:0]  mem [FIFO_DEPTH];
  logic        empty, full, pop, push, can_push;
  logic [1:0]  push_code;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = evt.evt_valid & evt.evt_ready;
  assign can_push = ~full | pop;

  assign g_kick = pend_kick & can_push;
  assign g_up   = pend_up & ~pend_kick & can_push;
  assign g_down = pend_down & ~pend_kick & ~pend_up & can_push;
  assign push   = g_kick | g_up | g_down;

  always_comb begin
    push_code = EVT_DOWN;
    if (g_kick)    push_code = EVT_KICK;
    else if (g_up) push_code = EVT_UP;
  end

  assign evt.evt_valid = ~empty;
  assign evt.evt_code  = empty ? 2'b00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop_up | drop_down | drop_kick) evt_overflow <= 1'b1;
    end
  end

`ifdef STRUM_PRESS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_up   <= '0;
      cnt_down <= '0;
      cnt_kick <= '0;
    end else begin
      if (start_up   && cnt_up   != 16'hFFFF) cnt_up   <= cnt_up + 1'b1;
      if (start_down && cnt_down != 16'hFFFF) cnt_down <= cnt_down + 1'b1;
      if (start_kick && cnt_kick != 16'hFFFF) cnt_kick <= cnt_kick + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_strum_press_gen.sv
// Directed bench for strum_press_gen with PRESS_CYCLES=5, HOLDOFF_CYCLES=3, FIFO_DEPTH=4.
module tb_strum_press_gen;

  logic clk = 1'b0;
  logic rst, strum_g, strum_b, drum_foot;
  logic press_up, press_down, press_kick, evt_overflow;
`ifdef STRUM_PRESS_STATS_EN
  logic [15:0] cnt_up, cnt_down, cnt_kick;
`endif
  int n_chk = 0;
  int n_bad = 0;

  strum_press_gen_if evt_if ();

  strum_press_gen #(.PRESS_CYCLES(5), .HOLDOFF_CYCLES(3), .CNT_W(20), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .strum_g(strum_g), .strum_b(strum_b), .drum_foot(drum_foot),
    .press_up(press_up), .press_down(press_down), .press_kick(press_kick),
    .evt(evt_if), .evt_overflow(evt_overflow)
`ifdef STRUM_PRESS_STATS_EN
    , .cnt_up(cnt_up), .cnt_down(cnt_down), .cnt_kick(cnt_kick)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pops;

  initial begin
    rst = 1'b1; strum_g = 1'b1; strum_b = 1'b0; drum_foot = 1'b0;
    evt_if.evt_ready = 1'b0;
    #1;
    repeat (3) tick();
    chk("rst_press_up", press_up, 1'b0);
    chk("rst_press_down", press_down, 1'b0);
    chk("rst_press_kick", press_kick, 1'b0);
    chk("rst_valid", evt_if.evt_valid, 1'b0);
    chk("rst_code", evt_if.evt_code, 2'b00);
    chk("rst_ovf", evt_overflow, 1'b0);

    // strum_g held high through reset release must not fire
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_high_up", press_up, 1'b0);
      chk("hold_high_valid", evt_if.evt_valid, 1'b0);
    end

    // single presses, holdoff rejection, and rise on the HOLDOFF->IDLE cycle
    evt_if.evt_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      strum_g = (c >= 2 && c <= 3) || (c >= 10 && c <= 12);
      strum_b = (c >= 10 && c <= 13) || (c >= 17 && c <= 18) || (c >= 20 && c <= 22);
      chk("single_up", press_up, (c >= 3 && c <= 7));
      chk("single_down", press_down, (c >= 11 && c <= 15) || (c >= 21 && c <= 25));
      chk("single_valid", evt_if.evt_valid, (c == 4 || c == 12 || c == 22));
      if (c == 4) chk("single_code_up", evt_if.evt_code, 2'b01);
      if (c == 12 || c == 22) chk("single_code_down", evt_if.evt_code, 2'b10);
      tick();
    end

    // simultaneous rises: pulses together, events kick, up, down
    for (int s = 0; s < 12; s++) begin
      strum_g = (s <= 1); strum_b = (s <= 1); drum_foot = (s <= 1);
      chk("simul_up", press_up, (s >= 1 && s <= 5));
      chk("simul_down", press_down, (s >= 1 && s <= 5));
      chk("simul_kick", press_kick, (s >= 1 && s <= 5));
      chk("simul_valid", evt_if.evt_valid, (s >= 2 && s <= 4));
      if (s == 2) chk("simul_code0", evt_if.evt_code, 2'b11);
      if (s == 3) chk("simul_code1", evt_if.evt_code, 2'b01);
      if (s == 4) chk("simul_code2", evt_if.evt_code, 2'b10);
      tick();
    end

    // backpressure: six kicks with ready low
    evt_if.evt_ready = 1'b0;
    for (int k = 0; k < 80; k++) begin
      drum_foot = (k <= 61) && ((k % 12) <= 1);
      if (k == 2)  chk("bp_first_valid", evt_if.evt_valid, 1'b1);
      if (k == 2)  chk("bp_first_code", evt_if.evt_code, 2'b11);
      if (k == 50) chk("bp_full_ovf", evt_overflow, 1'b0);
      if (k == 60) chk("bp_pre6_ovf", evt_overflow, 1'b0);
      if (k == 61) chk("bp_6th_press", press_kick, 1'b1);
      if (k == 62) chk("bp_post6_ovf", evt_overflow, 1'b1);
      if (k == 79) chk("bp_stable_code", evt_if.evt_code, 2'b11);
      tick();
    end

    evt_if.evt_ready = 1'b1;
    pops = 0;
    for (int d = 0; d < 20; d++) begin
      if (evt_if.evt_valid) begin
        pops++;
        chk("drain_code", evt_if.evt_code, 2'b11);
      end
      tick();
    end
    chk("drain_count", pops, 5);
    chk("drain_ovf_sticky", evt_overflow, 1'b1);
    chk("drain_empty", evt_if.evt_valid, 1'b0);

    // reset mid-press with two events queued
    evt_if.evt_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      strum_g = (r <= 1); strum_b = (r <= 1);
      tick();
    end
    chk("mid_pre_press", press_up, 1'b1);
    chk("mid_pre_valid", evt_if.evt_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_press_up", press_up, 1'b0);
    chk("mid_press_down", press_down, 1'b0);
    chk("mid_valid", evt_if.evt_valid, 1'b0);
    chk("mid_ovf", evt_overflow, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", evt_if.evt_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
